// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data load/store.
// Optional request watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int STARVE_MAX     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_rd_en,
   input  logic        d_wr_en,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_type,
   output logic [31:0] d_rdata,
   output logic        d_valid,
`ifdef MEM_ARB_TIMEOUT_EN
   output logic        timeout_err,
`endif
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_type,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_param_check
      $error("mem_port_arbiter: parameter out of range");
   end

   logic [1:0]  state;
   logic [3:0]  starve_cnt;
   logic        d_req;
   logic        grant_d;
   logic        grant_f;
   logic        busy;
   logic        complete;
   logic        to_hit;
   logic [31:0] rdata_in;

   assign d_req    = d_rd_en | d_wr_en;
   assign grant_d  = (state == IDLE) && d_req && (!if_req || (starve_cnt < STARVE_LIM));
   assign grant_f  = (state == IDLE) && !grant_d && if_req;
   assign busy     = (state == FETCH) || (state == DATA);
   assign complete = busy && (mem_ack || to_hit);
   assign rdata_in = to_hit ? TIMEOUT_DATA : mem_rdata;

   // Forced to zero during reset so every output reads 0 while rst is low.
   assign stall = rst & ((d_req & ~d_valid) | (if_req & ~if_valid));

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [6:0] TO_LAST = 7'(TIMEOUT_CYCLES - 1);
   logic [6:0] to_cnt;

   assign to_hit = busy && !mem_ack && (to_cnt == TO_LAST);

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         to_cnt <= (busy && !complete) ? to_cnt + 7'd1 : 7'd0;
         if (to_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         if_rdata   <= '0;
         if_valid   <= 1'b0;
         d_rdata    <= '0;
         d_valid    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_type   <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= DATA;
                  mem_req   <= 1'b1;
                  mem_we    <= d_wr_en;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_type  <= d_type;
                  if (!if_req)
                     starve_cnt <= '0;
                  else if (starve_cnt != STARVE_LIM)
                     starve_cnt <= starve_cnt + 4'd1;
               end else if (grant_f) begin
                  state      <= FETCH;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_type   <= 3'b010;
                  starve_cnt <= '0;
               end
            end
            FETCH, DATA: begin
               if (complete) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if (state == FETCH) begin
                     if_rdata <= rdata_in;
                     if_valid <= 1'b1;
                  end else begin
                     d_valid <= 1'b1;
                     // Stores keep the last load value unless the watchdog fired.
                     if (!mem_we || to_hit) d_rdata <= rdata_in;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: responder memory model, directed stimulus, valid-driven monitor.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_rd_en;
   logic        d_wr_en;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_type;
   logic [31:0] d_rdata;
   logic        d_valid;
`ifdef MEM_ARB_TIMEOUT_EN
   logic        timeout_err;
`endif
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_type;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_if[$];
   logic [31:0] exp_d[$];
   logic [31:0] grant_log[$];
   logic [31:0] mem_model[logic [31:0]];

   int ack_lat  = 0;
   bit ack_hold = 1'b0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYCLES(64)) dut (
      .CLK(CLK), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_type(d_type), .d_rdata(d_rdata), .d_valid(d_valid),
`ifdef MEM_ARB_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : ~a;
   endfunction

   // Memory responder: acks after ack_lat idle request cycles unless held off.
   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge CLK);
         #1;
         mem_ack = 1'b0;
         if (mem_req && !ack_hold) begin
            if (wait_cnt == ack_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_read(mem_addr);
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               wait_cnt  = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: pops expected read data on each valid pulse, logs grants, checks request stability.
   initial begin
      logic        prev_req;
      logic [31:0] prev_addr;
      logic [31:0] prev_wdata;
      logic        prev_we;
      prev_req = 1'b0;
      prev_addr = '0;
      prev_wdata = '0;
      prev_we = 1'b0;
      forever begin
         @(negedge CLK);
         if (if_valid) begin
            if (exp_if.size() == 0) check("if_unexpected_valid", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, exp_if.pop_front());
         end
         if (d_valid) begin
            if (exp_d.size() == 0) check("d_unexpected_valid", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, exp_d.pop_front());
         end
         if (mem_req && !prev_req) grant_log.push_back(mem_addr);
         if (mem_req && prev_req) begin
            check("mem_addr_stable", mem_addr, prev_addr);
            check("mem_wdata_stable", mem_wdata, prev_wdata);
            check("mem_we_stable", {31'd0, mem_we}, {31'd0, prev_we});
         end
         prev_req   = mem_req;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
         prev_we    = mem_we;
      end
   end

   task automatic wait_if(output int cyc);
      cyc = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge CLK);
         if (if_valid) begin
            cyc = n;
            break;
         end
      end
      if (cyc < 0) check("if_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_d(output int cyc);
      cyc = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge CLK);
         if (d_valid) begin
            cyc = n;
            break;
         end
      end
      if (cyc < 0) check("d_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_mem_type"}, {29'd0, mem_type}, 32'd0);
      check({tag, "_if_rdata"}, if_rdata, 32'd0);
      check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
      check({tag, "_d_rdata"}, d_rdata, 32'd0);
      check({tag, "_d_valid"}, {31'd0, d_valid}, 32'd0);
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
   endtask

   initial begin
      int c;
      logic [31:0] pat[10];
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_rd_en = 1'b0; d_wr_en = 1'b0; d_addr = '0; d_wdata = '0; d_type = '0;
      mem_model[32'h100]  = 32'h0050_0093;
      mem_model[32'h2000] = 32'h1122_3344;
      #3 rst = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);

      // Fetch only, ack in the third request cycle.
      ack_lat = 2;
      exp_if.push_back(32'h0050_0093);
      if_req = 1'b1; if_addr = 32'h100;
      @(negedge CLK);
      check("f_mem_req", {31'd0, mem_req}, 32'd1);
      check("f_mem_we", {31'd0, mem_we}, 32'd0);
      check("f_mem_type", {29'd0, mem_type}, 32'd2);
      check("f_mem_addr", mem_addr, 32'h100);
      check("f_stall_busy", {31'd0, stall}, 32'd1);
      wait_if(c);
      check("f_latency", c, 32'd3);
      check("f_stall_at_valid", {31'd0, stall}, 32'd0);
      if_req = 1'b0;
      @(negedge CLK);
      check("f_valid_one_pulse", {31'd0, if_valid}, 32'd0);
      check("f_stall_after", {31'd0, stall}, 32'd0);

      // Simultaneous fetch and load: data wins.
      ack_lat = 0;
      exp_d.push_back(32'h1122_3344);
      exp_if.push_back(32'hFFFF_FEFB);
      if_req = 1'b1; if_addr = 32'h104;
      d_rd_en = 1'b1; d_addr = 32'h2000; d_type = 3'b100;
      @(negedge CLK);
      check("p_first_addr", mem_addr, 32'h2000);
      check("p_type_pass", {29'd0, mem_type}, 32'd4);
      wait_d(c);
      check("p_d_latency", c, 32'd1);
      check("p_if_not_yet", {31'd0, if_valid}, 32'd0);
      d_rd_en = 1'b0;
      @(negedge CLK);
      check("p_idle_after_done", {31'd0, mem_req}, 32'd0);
      @(negedge CLK);
      check("p_fetch_req", {31'd0, mem_req}, 32'd1);
      check("p_fetch_addr", mem_addr, 32'h104);
      wait_if(c);
      check("p_if_latency", c, 32'd1);
      if_req = 1'b0;
      @(negedge CLK);

      // Store: d_rdata keeps previous load value.
      ack_lat = 3;
      exp_d.push_back(32'h1122_3344);
      d_wr_en = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D; d_type = 3'b010;
      @(negedge CLK);
      check("s_mem_we", {31'd0, mem_we}, 32'd1);
      check("s_mem_addr", mem_addr, 32'h40);
      check("s_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check("s_mem_type", {29'd0, mem_type}, 32'd2);
      wait_d(c);
      check("s_latency", c, 32'd4);
      d_wr_en = 1'b0;
      check("s_mem_written", mem_read(32'h40), 32'hCAFE_F00D);
      @(negedge CLK);

      // Starvation: 4 data grants, 1 fetch, repeat.
      ack_lat = 0;
      grant_log.delete();
      for (int i = 0; i < 10; i++) begin
         pat[i] = ((i % 5) == 4) ? 32'h400 : 32'h3000;
         if ((i % 5) == 4) exp_if.push_back(32'hFFFF_FBFF);
         else exp_d.push_back(32'hFFFF_CFFF);
      end
      if_req = 1'b1; if_addr = 32'h400;
      d_rd_en = 1'b1; d_addr = 32'h3000; d_type = 3'b000;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         #1;
         if (grant_log.size() >= 10) break;
      end
      if_req = 1'b0; d_rd_en = 1'b0;
      check("st_grant_count", grant_log.size(), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < grant_log.size()) check($sformatf("st_grant_%0d", i), grant_log[i], pat[i]);
      wait_if(c);
      @(negedge CLK);

      // Reset with a request pending.
      ack_hold = 1'b1;
      if_req = 1'b1; if_addr = 32'h500;
      @(negedge CLK);
      check("r_req_pending", {31'd0, mem_req}, 32'd1);
      @(negedge CLK);
      #2 rst = 1'b0;
      #1 check_all_zero("midrst");
      if_req = 1'b0;
      ack_hold = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
      exp_if.push_back(32'hFFFF_F9FF);
      if_req = 1'b1; if_addr = 32'h600;
      @(negedge CLK);
      check("r_new_req", {31'd0, mem_req}, 32'd1);
      check("r_new_addr", mem_addr, 32'h600);
      wait_if(c);
      check("r_new_latency", c, 32'd1);
      if_req = 1'b0;
      @(negedge CLK);

`ifdef MEM_ARB_TIMEOUT_EN
      // Watchdog: no ack ever arrives.
      ack_hold = 1'b1;
      exp_d.push_back(32'hDEAD_BEEF);
      d_rd_en = 1'b1; d_addr = 32'h700;
      c = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (d_valid) break;
         if (mem_req) c++;
      end
      check("t_req_cycles", c, 32'd64);
      check("t_req_dropped", {31'd0, mem_req}, 32'd0);
      check("t_err_set", {31'd0, timeout_err}, 32'd1);
      d_rd_en = 1'b0;
      ack_hold = 1'b0;
      repeat (5) @(negedge CLK);
      check("t_err_sticky", {31'd0, timeout_err}, 32'd1);
      rst = 1'b0;
      #1 check("t_err_cleared", {31'd0, timeout_err}, 32'd0);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
`endif

      check("sb_if_drained", exp_if.size(), 32'd0);
      check("sb_d_drained", exp_d.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

endmodule
